half_vector_pack: RTL and testbench

//  Stream-to-vector packer ahead of the half-precision reduction tree (half_sum_v).

---
 rtl/half_vector_pack_if.sv | 26 ++
 rtl/half_vector_pack.sv | 151 +++++++++++++++
 tb/tb_half_vector_pack.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/half_vector_pack_if.sv
// Stream-in / vector-out handshake bundle for half_vector_pack.
// The master modport is the producer/consumer side; the slave modport is the packer.
interface half_vector_pack_if #(
  parameter int WIDTH = 10
);
  localparam int CW = $clog2(WIDTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_vector [WIDTH];
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vector, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vector, out_count
  );
endinterface

// File: rtl/half_vector_pack.sv
// Packs a stream of 16-bit half-float words into WIDTH-element vectors, zero-padding
// short vectors closed by in_last; a fill buffer plus an output register double-buffer the path.
module half_vector_pack #(
  parameter int WIDTH = 10
) (
  input logic               clk,
  input logic               rst,
  half_vector_pack_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] pend_count_r;
  logic [15:0]   fill_r       [WIDTH];
  logic [15:0]   fill_img_s   [WIDTH];
  logic [15:0]   out_vector_r [WIDTH];
  logic [CW-1:0] out_count_r;
  logic          out_valid_r;

  logic in_ready_s;
  logic accept_s;
  logic consume_s;
  logic complete_s;
  logic out_free_s;
  logic direct_move_s;
  logic pend_move_s;

  assign in_ready_s     = (state_r == FILL) & ~rst;
  assign accept_s       = bus.in_valid & in_ready_s;
  assign consume_s      = out_valid_r & bus.out_ready;
  assign complete_s     = accept_s & ((cnt_r == CW'(WIDTH - 1)) | bus.in_last);
  assign out_free_s     = ~out_valid_r | bus.out_ready;

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_vector = out_vector_r;
  assign bus.out_count  = out_count_r;

  // Completed-vector image: earlier words, the word accepted now, zero padding above it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(cnt_r)) begin
        fill_img_s[i] = fill_r[i];
      end else if (i == int'(cnt_r)) begin
        fill_img_s[i] = bus.in_data;
      end else begin
        fill_img_s[i] = 16'h0000;
      end
    end
  end

  // Fill FSM next state and move decisions.
  always_comb begin
    state_s       = state_r;
    direct_move_s = 1'b0;
    pend_move_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (complete_s) begin
          if (out_free_s) begin
            direct_move_s = 1'b1;
            state_s       = FILL;
          end else begin
            state_s       = PEND;
          end
        end else begin
          state_s = FILL;
        end
      end
      PEND: begin
        if (consume_s) begin
          pend_move_s = 1'b1;
          state_s     = FILL;
        end else begin
          state_s     = PEND;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // Fill FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Word counter and fill buffer; a vector that cannot move straight out is parked here.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {CW{1'b0}};
      pend_count_r <= {CW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        fill_r[i] <= 16'h0000;
      end
    end else begin
      if (complete_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (complete_s & ~direct_move_s) begin
        fill_r       <= fill_img_s;
        pend_count_r <= cnt_r + CW'(1);
      end else if (accept_s) begin
        fill_r[cnt_r] <= bus.in_data;
      end else begin
        pend_count_r <= pend_count_r;
      end
    end
  end

  // Output register: loaded on a move, held stable otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_count_r <= {CW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        out_vector_r[i] <= 16'h0000;
      end
    end else begin
      if (direct_move_s) begin
        out_vector_r <= fill_img_s;
        out_count_r  <= cnt_r + CW'(1);
        out_valid_r  <= 1'b1;
      end else if (pend_move_s) begin
        out_vector_r <= fill_r;
        out_count_r  <= pend_count_r;
        out_valid_r  <= 1'b1;
      end else if (consume_s) begin
        out_valid_r  <= 1'b0;
      end else begin
        out_valid_r  <= out_valid_r;
      end
    end
  end
endmodule

// File: tb/tb_half_vector_pack.sv
// Bench for half_vector_pack: directed vectors with literal expectations plus a
// queue-based model of the packing rules checked on every transfer.
module tb_half_vector_pack;
  localparam int WIDTH = 10;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  half_vector_pack_if #(.WIDTH(WIDTH)) bus ();
  half_vector_pack #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  logic done = 1'b0;

  // Model state: words of the vector being collected, and completed vectors awaiting transfer.
  logic [15:0] cur_q   [$];
  int          exp_n_q [$];
  logic [15:0] exp_w_q [$];
  logic        hold = 1'b0;
  logic [15:0] held_v [WIDTH];
  logic [CW-1:0] held_c;
  int          n_exp;
  logic [15:0] w_exp;
  logic        same;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: scoreboard on transfers, stability while stalled, model update on accepts.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
      cur_q.delete();
      exp_n_q.delete();
      exp_w_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        same = (bus.out_count == held_c) && bus.out_valid;
        for (int i = 0; i < WIDTH; i++) if (bus.out_vector[i] !== held_v[i]) same = 1'b0;
        chk("stable_while_stalled", {31'd0, same}, 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_n_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_vector: got out_count %0d expected no vector", bus.out_count);
        end else begin
          n_exp = exp_n_q.pop_front();
          chk("sb_count", 32'(bus.out_count), 32'(n_exp));
          for (int i = 0; i < WIDTH; i++) begin
            w_exp = exp_w_q.pop_front();
            chk($sformatf("sb_elem%0d", i), 32'(bus.out_vector[i]), 32'(w_exp));
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        cur_q.push_back(bus.in_data);
        if (cur_q.size() == WIDTH || bus.in_last) begin
          exp_n_q.push_back(cur_q.size());
          for (int i = 0; i < WIDTH; i++) exp_w_q.push_back(i < cur_q.size() ? cur_q[i] : 16'h0000);
          cur_q.delete();
        end
      end
      hold   = bus.out_valid && !bus.out_ready;
      held_c = bus.out_count;
      for (int i = 0; i < WIDTH; i++) held_v[i] = bus.out_vector[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      stalls++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t2 [3];
    int len;
    t2 = '{16'h4000, 16'h4200, 16'h4400};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < WIDTH; i++) chk("rst_out_vector", 32'(bus.out_vector[i]), 32'd0);
    step();

    // Ten 1.0 words back to back: one pulse right after the tenth.
    stalls = 0;
    for (int i = 0; i < 10; i++) send(16'h3C00, 1'b0);
    @(negedge clk);
    chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("full_count", 32'(bus.out_count), 32'd10);
    for (int i = 0; i < WIDTH; i++) chk("full_elem", 32'(bus.out_vector[i]), 32'h3C00);
    @(negedge clk);
    chk("full_pulse_end", {31'd0, bus.out_valid}, 32'd0);
    chk("full_no_stall", 32'(stalls), 32'd0);
    step();

    // Short vector closed by in_last.
    send(16'h4000, 1'b0);
    send(16'h4200, 1'b0);
    send(16'h4400, 1'b1);
    @(negedge clk);
    chk("short_count", 32'(bus.out_count), 32'd3);
    for (int i = 0; i < WIDTH; i++)
      chk("short_elem", 32'(bus.out_vector[i]), i < 3 ? 32'(t2[i]) : 32'd0);
    step();

    // Twenty words with out_ready=1 must stream without a bubble.
    stalls = 0;
    for (int i = 0; i < 20; i++) send(16'h0A00 + 16'(i), 1'b0);
    chk("stream_no_stall", 32'(stalls), 32'd0);
    repeat (2) step();

    // Back-pressure: first vector held, second parked, 21st word stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(16'h1000 + 16'(i), 1'b0);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_elem0", 32'(bus.out_vector[0]), 32'h1000);
    chk("bp_count", 32'(bus.out_count), 32'd10);
    step();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h2000;
    bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_elem9", 32'(bus.out_vector[9]), 32'h1009);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_first", 32'(bus.out_vector[0]), 32'h1000);
    step();
    @(negedge clk);
    chk("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_second_elem0", 32'(bus.out_vector[0]), 32'h100A);
    chk("bp_second_count", 32'(bus.out_count), 32'd10);
    chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    @(negedge clk);
    chk("bp_w21_count", 32'(bus.out_count), 32'd1);
    chk("bp_w21_elem0", 32'(bus.out_vector[0]), 32'h2000);
    chk("bp_w21_elem1", 32'(bus.out_vector[1]), 32'h0000);
    step();

    // Single NaN word, then a new vector must start at element 0.
    send(16'h7C01, 1'b1);
    @(negedge clk);
    chk("single_count", 32'(bus.out_count), 32'd1);
    chk("single_elem0", 32'(bus.out_vector[0]), 32'h7C01);
    chk("single_elem9", 32'(bus.out_vector[9]), 32'h0000);
    step();
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b1);
    @(negedge clk);
    chk("after_single_count", 32'(bus.out_count), 32'd2);
    chk("after_single_elem0", 32'(bus.out_vector[0]), 32'hAAAA);
    chk("after_single_elem1", 32'(bus.out_vector[1]), 32'h5555);
    chk("after_single_elem2", 32'(bus.out_vector[2]), 32'h0000);
    step();

    // Reset mid-vector discards the partial words.
    for (int i = 0; i < 5; i++) send(16'h0500 + 16'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_count", 32'(bus.out_count), 32'd0);
    step();
    for (int i = 0; i < 10; i++) send(16'h0100 + 16'(i), 1'b0);
    @(negedge clk);
    chk("postrst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("postrst_elem0", 32'(bus.out_vector[0]), 32'h0100);
    chk("postrst_count", 32'(bus.out_count), 32'd10);
    step();

    // Random vectors, gaps and back-pressure; the compare process scores everything.
    fork
      begin
        for (int v = 0; v < 100; v++) begin
          len = $urandom_range(1, WIDTH);
          for (int j = 0; j < len; j++) begin
            repeat ($urandom_range(0, 2)) step();
            send(16'($urandom), (j == len - 1) ? ((len < WIDTH) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("drain_vectors_left", 32'(exp_n_q.size()), 32'd0);
    chk("drain_words_left", 32'(cur_q.size()), 32'd0);
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
